// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - RV32I ALU/compare opcode encodings and shared-ALU request helpers
package rv32i_types;

  typedef enum logic [2:0] {
    alu_add = 3'b000,
    alu_sll = 3'b001,
    alu_sra = 3'b010,
    alu_sub = 3'b011,
    alu_xor = 3'b100,
    alu_srl = 3'b101,
    alu_or  = 3'b110,
    alu_and = 3'b111
  } alu_ops;

  typedef enum logic [2:0] {
    beq  = 3'b000,
    bne  = 3'b001,
    blt  = 3'b100,
    bge  = 3'b101,
    bltu = 3'b110,
    bgeu = 3'b111
  } branch_funct3_t;

  localparam int ALU_TAG_W = 4;

  typedef struct packed {
    logic                 aluc;
    logic [2:0]           aluop;
    logic [31:0]          a;
    logic [31:0]          b;
    logic [ALU_TAG_W-1:0] tag;
  } alu_req_t;

  // Compare codes 010/011 have no branch meaning.
  function automatic logic is_illegal_aluop(input logic aluc, input logic [2:0] aluop);
    return !aluc && (aluop[2:1] == 2'b01);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin priority encoder starting at rr_ptr_i
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  elig_i,
  input  logic [IW-1:0] rr_ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] grant_idx_o,
  output logic          any_grant_o
);

  logic [2*N-1:0] dbl;

  assign dbl = {elig_i, elig_i};

  // Scan downward so the lowest offset from rr_ptr_i wins.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    any_grant_o = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (dbl[int'(rr_ptr_i) + k]) begin
        any_grant_o = 1'b1;
        grant_idx_o = IW'((int'(rr_ptr_i) + k) % N);
      end
    end
    if (any_grant_o) grant_o[grant_idx_o] = 1'b1;
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one combinational ALU with registered per-requester responses
module alu_share_arbiter
  import rv32i_types::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TAG_W   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_aluc,
  input  logic [NUM_REQ-1:0][2:0]       req_aluop,
  input  logic [NUM_REQ-1:0][31:0]      req_a,
  input  logic [NUM_REQ-1:0][31:0]      req_b,
  input  logic [NUM_REQ-1:0][TAG_W-1:0] req_tag,
  output logic                          alu_aluc,
  output logic [2:0]                    alu_aluop,
  output logic [31:0]                   alu_a,
  output logic [31:0]                   alu_b,
  input  logic [31:0]                   alu_f,
  output logic [NUM_REQ-1:0]            resp_valid,
  input  logic [NUM_REQ-1:0]            resp_ready,
  output logic [NUM_REQ-1:0][31:0]      resp_data,
  output logic [NUM_REQ-1:0][TAG_W-1:0] resp_tag,
  output logic [NUM_REQ-1:0]            resp_err,
  output logic [31:0]                   conflict_cnt
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]            elig, grant;
  logic [IW-1:0]                 grant_idx, rr_ptr_q, rr_ptr_d;
  logic                          any_grant, illegal, conflict;
  logic [31:0]                   result, conflict_cnt_q, conflict_cnt_d;
  logic [NUM_REQ-1:0]            resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
  logic [NUM_REQ-1:0][31:0]      resp_data_q, resp_data_d;
  logic [NUM_REQ-1:0][TAG_W-1:0] resp_tag_q, resp_tag_d;
  int                            n_elig;

  // A full slot can accept a new result only if it drains this same cycle.
  assign elig = req_valid & (~resp_valid_q | resp_ready);

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .elig_i      (elig),
    .rr_ptr_i    (rr_ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .any_grant_o (any_grant)
  );

  assign req_ready = grant;

  always_comb begin
    alu_aluc  = 1'b1;
    alu_aluop = alu_add;
    alu_a     = '0;
    alu_b     = '0;
    if (any_grant) begin
      alu_aluc  = req_aluc[grant_idx];
      alu_aluop = req_aluop[grant_idx];
      alu_a     = req_a[grant_idx];
      alu_b     = req_b[grant_idx];
    end
  end

  assign illegal = any_grant && is_illegal_aluop(alu_aluc, alu_aluop);
  assign result  = illegal ? 32'h0 : alu_f;

  always_comb begin
    n_elig = 0;
    for (int i = 0; i < NUM_REQ; i++) n_elig += int'(elig[i]);
    conflict = (n_elig >= 2);
  end

  always_comb begin
    resp_valid_d = resp_valid_q & ~resp_ready;
    resp_data_d  = resp_data_q;
    resp_tag_d   = resp_tag_q;
    resp_err_d   = resp_err_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        resp_valid_d[i] = 1'b1;
        resp_data_d[i]  = result;
        resp_tag_d[i]   = req_tag[i];
        resp_err_d[i]   = illegal;
      end
    end
    rr_ptr_d = rr_ptr_q;
    if (any_grant) rr_ptr_d = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
    conflict_cnt_d = conflict_cnt_q;
    if (conflict && (conflict_cnt_q != 32'hFFFF_FFFF)) conflict_cnt_d = conflict_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid_q   <= '0;
      resp_data_q    <= '0;
      resp_tag_q     <= '0;
      resp_err_q     <= '0;
      rr_ptr_q       <= '0;
      conflict_cnt_q <= '0;
    end else begin
      resp_valid_q   <= resp_valid_d;
      resp_data_q    <= resp_data_d;
      resp_tag_q     <= resp_tag_d;
      resp_err_q     <= resp_err_d;
      rr_ptr_q       <= rr_ptr_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign resp_valid   = resp_valid_q;
  assign resp_data    = resp_data_q;
  assign resp_tag     = resp_tag_q;
  assign resp_err     = resp_err_q;
  assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed table-driven bench for alu_share_arbiter with looped-back ALU model
module tb_alu_share_arbiter;
  import rv32i_types::*;

  localparam int NR = 2;
  localparam int TW = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NR-1:0]          req_valid, req_ready, req_aluc;
  logic [NR-1:0][2:0]     req_aluop;
  logic [NR-1:0][31:0]    req_a, req_b;
  logic [NR-1:0][TW-1:0]  req_tag;
  logic                   alu_aluc;
  logic [2:0]             alu_aluop;
  logic [31:0]            alu_a, alu_b, alu_f;
  logic [NR-1:0]          resp_valid, resp_ready, resp_err;
  logic [NR-1:0][31:0]    resp_data;
  logic [NR-1:0][TW-1:0]  resp_tag;
  logic [31:0]            conflict_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.NUM_REQ(NR), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_aluc(req_aluc), .req_aluop(req_aluop),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .alu_aluc(alu_aluc), .alu_aluop(alu_aluop), .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_tag(resp_tag), .resp_err(resp_err), .conflict_cnt(conflict_cnt)
  );

  // Reference ALU; illegal compare codes return garbage that must never reach resp_data.
  function automatic logic [31:0] pipeline_alu(input logic aluc, input logic [2:0] op,
                                               input logic [31:0] a, input logic [31:0] b);
    if (aluc) begin
      case (op)
        3'b000:  return a + b;
        3'b001:  return a << b[4:0];
        3'b010:  return $signed(a) >>> b[4:0];
        3'b011:  return a - b;
        3'b100:  return a ^ b;
        3'b101:  return a >> b[4:0];
        3'b110:  return a | b;
        default: return a & b;
      endcase
    end
    case (op)
      3'b000:  return {31'b0, a == b};
      3'b001:  return {31'b0, a != b};
      3'b100:  return {31'b0, $signed(a) < $signed(b)};
      3'b101:  return {31'b0, $signed(a) >= $signed(b)};
      3'b110:  return {31'b0, a < b};
      3'b111:  return {31'b0, a >= b};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign alu_f = pipeline_alu(alu_aluc, alu_aluop, alu_a, alu_b);

  typedef struct {
    alu_req_t    req;
    int          who;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    req_valid  = '0;
    req_aluc   = '0;
    req_aluop  = '0;
    req_a      = '0;
    req_b      = '0;
    req_tag    = '0;
    resp_ready = '1;
  endtask

  task automatic drive(input int who, input alu_req_t r);
    req_valid[who] = 1'b1;
    req_aluc[who]  = r.aluc;
    req_aluop[who] = r.aluop;
    req_a[who]     = r.a;
    req_b[who]     = r.b;
    req_tag[who]   = r.tag;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] exp_gnt;

    vecs[0]  = '{'{1'b1, 3'b000, 32'd5,          32'd7,          4'd3},  0, 32'd12,         1'b0};
    vecs[1]  = '{'{1'b0, 3'b100, 32'hFFFF_FFFF,  32'd1,          4'd5},  1, 32'd1,          1'b0};
    vecs[2]  = '{'{1'b0, 3'b110, 32'hFFFF_FFFF,  32'd1,          4'd6},  1, 32'd0,          1'b0};
    vecs[3]  = '{'{1'b1, 3'b011, 32'd10,         32'd3,          4'd7},  0, 32'd7,          1'b0};
    vecs[4]  = '{'{1'b0, 3'b010, 32'd9,          32'd4,          4'd9},  0, 32'd0,          1'b1};
    vecs[5]  = '{'{1'b0, 3'b011, 32'd1,          32'd2,          4'd10}, 1, 32'd0,          1'b1};
    vecs[6]  = '{'{1'b1, 3'b010, 32'h8000_0000,  32'd4,          4'd11}, 0, 32'hF800_0000,  1'b0};
    vecs[7]  = '{'{1'b0, 3'b101, 32'hFFFF_FFFB,  32'hFFFF_FFFB,  4'd12}, 1, 32'd1,          1'b0};
    vecs[8]  = '{'{1'b0, 3'b111, 32'd1,          32'hFFFF_FFFF,  4'd13}, 0, 32'd0,          1'b0};
    vecs[9]  = '{'{1'b1, 3'b100, 32'h0000_F0F0,  32'h0000_0FF0,  4'd14}, 1, 32'h0000_FF00,  1'b0};
    vecs[10] = '{'{1'b1, 3'b001, 32'd1,          32'd31,         4'd15}, 0, 32'h8000_0000,  1'b0};
    vecs[11] = '{'{1'b0, 3'b000, 32'd3,          32'd4,          4'd1},  1, 32'd0,          1'b0};

    rst = 1'b1;
    idle_inputs();
    @(negedge clk); #1;
    chk("reset resp_valid", 32'(resp_valid), 32'h0);
    chk("reset conflict_cnt", conflict_cnt, 32'h0);
    chk("reset resp_data0", resp_data[0], 32'h0);
    chk("idle req_ready", 32'(req_ready), 32'h0);
    chk("idle alu_aluc", 32'(alu_aluc), 32'h1);
    chk("idle alu_aluop", 32'(alu_aluop), 32'h0);
    chk("idle alu_a", alu_a, 32'h0);
    chk("idle alu_b", alu_b, 32'h0);
    rst = 1'b0;

    for (int v = 0; v < 12; v++) begin
      @(negedge clk);
      idle_inputs();
      drive(vecs[v].who, vecs[v].req);
      exp_gnt = 2'(1 << vecs[v].who);
      #1;
      chk($sformatf("vec%0d req_ready", v), 32'(req_ready), 32'(exp_gnt));
      chk($sformatf("vec%0d alu_a", v), alu_a, vecs[v].req.a);
      @(posedge clk); #1;
      chk($sformatf("vec%0d resp_valid", v), 32'(resp_valid[vecs[v].who]), 32'h1);
      chk($sformatf("vec%0d resp_data", v), resp_data[vecs[v].who], vecs[v].exp_data);
      chk($sformatf("vec%0d resp_tag", v), 32'(resp_tag[vecs[v].who]), 32'(vecs[v].req.tag));
      chk($sformatf("vec%0d resp_err", v), 32'(resp_err[vecs[v].who]), 32'(vecs[v].exp_err));
    end

    // Contention: both requesters held valid must alternate starting at 0.
    @(negedge clk);
    idle_inputs();
    rst = 1'b1; #1; rst = 1'b0;
    chk("pulse reset conflict_cnt", conflict_cnt, 32'h0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      idle_inputs();
      drive(0, '{1'b1, 3'b000, 32'd1, 32'd1, 4'(c)});
      drive(1, '{1'b1, 3'b000, 32'd2, 32'd2, 4'(c)});
      #1;
      chk($sformatf("rr cycle%0d req_ready", c), 32'(req_ready), (c % 2 == 0) ? 32'h1 : 32'h2);
      @(posedge clk);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    chk("rr conflict_cnt", conflict_cnt, 32'd4);
    @(posedge clk);

    // Stall: full slot blocks req0 until it drains, then regrant in the draining cycle.
    @(negedge clk);
    idle_inputs();
    resp_ready = 2'b10;
    drive(0, '{1'b1, 3'b011, 32'd10, 32'd3, 4'd2});
    #1;
    chk("stall first grant", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    chk("stall first data", resp_data[0], 32'd7);
    for (int s = 0; s < 3; s++) begin
      @(negedge clk); #1;
      chk($sformatf("stall%0d req_ready", s), 32'(req_ready), 32'h0);
      chk($sformatf("stall%0d resp_data", s), resp_data[0], 32'd7);
      @(posedge clk); #1;
      chk($sformatf("stall%0d resp_valid", s), 32'(resp_valid[0]), 32'h1);
    end
    @(negedge clk);
    resp_ready = 2'b11;
    drive(0, '{1'b1, 3'b000, 32'd1, 32'd1, 4'd8});
    #1;
    chk("drain regrant req_ready", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    chk("drain regrant resp_valid", 32'(resp_valid[0]), 32'h1);
    chk("drain regrant resp_data", resp_data[0], 32'd2);
    chk("drain regrant resp_tag", 32'(resp_tag[0]), 32'd8);
    chk("stall conflict_cnt", conflict_cnt, 32'd4);

    // Asynchronous reset mid-cycle clears state before any clock edge.
    @(negedge clk);
    idle_inputs();
    rst = 1'b1; #1; rst = 1'b0;
    @(negedge clk);
    drive(0, '{1'b1, 3'b000, 32'd1, 32'd1, 4'd4});
    drive(1, '{1'b1, 3'b000, 32'd2, 32'd2, 4'd5});
    #1;
    chk("pre-reset grant", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    chk("pre-reset conflict_cnt", conflict_cnt, 32'd1);
    chk("pre-reset resp_valid", 32'(resp_valid), 32'h1);
    @(negedge clk);
    idle_inputs();
    #2;
    rst = 1'b1;
    #1;
    chk("async reset resp_valid", 32'(resp_valid), 32'h0);
    chk("async reset conflict_cnt", conflict_cnt, 32'h0);
    chk("async reset resp_data0", resp_data[0], 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, '{1'b1, 3'b000, 32'd1, 32'd1, 4'd4});
    drive(1, '{1'b1, 3'b000, 32'd2, 32'd2, 4'd5});
    #1;
    chk("post-reset rr_ptr grant", 32'(req_ready), 32'h1);
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    drive(1, '{1'b1, 3'b000, 32'd20, 32'd22, 4'd6});
    #1;
    chk("post-reset req1 alone", 32'(req_ready), 32'h2);
    @(posedge clk); #1;
    chk("post-reset req1 data", resp_data[1], 32'd42);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
